// File: rtl/line_follow_sequencer.sv
// Route-level rover drive controller: debounces tape/proximity sensors, steers
// the motor pair while line following and executes a programmed turn per junction.
module line_follow_sequencer #(
  parameter int                     ROUTE_LEN    = 4,
  parameter logic [2*ROUTE_LEN-1:0] ROUTE        = 8'b11_01_00_10,
  parameter int                     DEB_CYCLES   = 4,
  parameter int                     CROSS_CYCLES = 50,
  parameter int                     TURN_MIN     = 20,
  parameter int                     TURN_MAX     = 1000,
  parameter int                     LOST_CYCLES  = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] induct,
  input  logic       proxim,
  input  logic       red,
  output logic [3:0] motorIn,
  output logic [1:0] motorEn,
  output logic [2:0] state,
  output logic [3:0] junc_idx,
  output logic       done,
  output logic       fault
);

  localparam int FW = $clog2(DEB_CYCLES + 1);
  localparam int CW = $clog2(CROSS_CYCLES + 1);
  localparam int TW = $clog2(TURN_MAX + 1);
  localparam int LW = $clog2(LOST_CYCLES + 1);

  localparam logic [FW-1:0] DEB_MAX    = FW'(DEB_CYCLES);
  localparam logic [CW-1:0] CROSS_LAST = CW'(CROSS_CYCLES - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'(TURN_MAX - 1);
  localparam logic [TW-1:0] TMIN_ONE   = TW'(TURN_MIN);
  localparam logic [TW-1:0] TMIN_TWO   = TW'(2 * TURN_MIN);
  localparam logic [LW-1:0] LOST_LAST  = LW'(LOST_CYCLES - 1);
  localparam logic [3:0]    LAST_JUNC  = 4'(ROUTE_LEN - 1);

  localparam logic [3:0] MOT_FWD   = 4'b0110;
  localparam logic [3:0] MOT_LEFT  = 4'b1010;
  localparam logic [3:0] MOT_RIGHT = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FOLLOW  = 3'd1,
    S_CROSS   = 3'd2,
    S_TURN    = 3'd3,
    S_BLOCKED = 3'd4,
    S_DONE    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  // sensor filters
  logic [2:0]    ind_samp_r, ind_f_r;
  logic [FW-1:0] ind_cnt_r, ind_cnt_nxt_s;
  logic          prox_samp_r, prox_f_r;
  logic [FW-1:0] prox_cnt_r, prox_cnt_nxt_s;

  // sequencer state
  state_t        state_r, state_nxt_s, ret_r, ret_nxt_s;
  logic [3:0]    junc_r, junc_nxt_s;
  logic [CW-1:0] cross_cnt_r, cross_cnt_nxt_s;
  logic [TW-1:0] spin_cnt_r, spin_cnt_nxt_s, spin_min_s;
  logic [LW-1:0] lost_cnt_r, lost_cnt_nxt_s;
  logic [3:0]    last_cmd_r, last_cmd_nxt_s;
  logic [3:0]    spin_dir_r, spin_dir_nxt_s;
  logic          uturn_r, uturn_nxt_s;
  logic [1:0]    code_s;
  logic [3:0]    mot_in_r, mot_in_nxt_s;
  logic [1:0]    mot_en_r, mot_en_nxt_s;
  logic          done_r, fault_r;

  // A run of equal samples saturates at DEB_MAX; any change restarts it at one.
  assign ind_cnt_nxt_s  = (induct == ind_samp_r)
                          ? ((ind_cnt_r == DEB_MAX) ? DEB_MAX : ind_cnt_r + FW'(1))
                          : FW'(1);
  assign prox_cnt_nxt_s = (proxim == prox_samp_r)
                          ? ((prox_cnt_r == DEB_MAX) ? DEB_MAX : prox_cnt_r + FW'(1))
                          : FW'(1);

  assign spin_min_s = uturn_r ? TMIN_TWO : TMIN_ONE;

  // Debounce history for the tape sensors and the proximity input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ind_samp_r  <= 3'b111;
      ind_cnt_r   <= '0;
      ind_f_r     <= 3'b111;
      prox_samp_r <= 1'b0;
      prox_cnt_r  <= '0;
      prox_f_r    <= 1'b0;
    end else begin
      ind_samp_r  <= induct;
      ind_cnt_r   <= ind_cnt_nxt_s;
      ind_f_r     <= (ind_cnt_nxt_s == DEB_MAX) ? induct : ind_f_r;
      prox_samp_r <= proxim;
      prox_cnt_r  <= prox_cnt_nxt_s;
      prox_f_r    <= (prox_cnt_nxt_s == DEB_MAX) ? proxim : prox_f_r;
    end
  end

  // Turn code of the junction currently being executed.
  always_comb begin
    code_s = 2'b00;
    for (int j = 0; j < ROUTE_LEN; j++) begin
      code_s = code_s | ((junc_r == 4'(j)) ? ROUTE[2*j +: 2] : 2'b00);
    end
  end

  // Next-state, counter and motor-command decode.
  always_comb begin
    state_nxt_s     = state_r;
    ret_nxt_s       = ret_r;
    junc_nxt_s      = junc_r;
    cross_cnt_nxt_s = cross_cnt_r;
    spin_cnt_nxt_s  = spin_cnt_r;
    lost_cnt_nxt_s  = lost_cnt_r;
    last_cmd_nxt_s  = last_cmd_r;
    spin_dir_nxt_s  = spin_dir_r;
    uturn_nxt_s     = uturn_r;

    if (red && (state_r != S_FAULT)) begin
      state_nxt_s = S_DONE;
    end else if (prox_f_r && ((state_r == S_FOLLOW) || (state_r == S_CROSS) ||
                              (state_r == S_TURN))) begin
      // Everything else is frozen so the interrupted activity resumes intact.
      state_nxt_s = S_BLOCKED;
      ret_nxt_s   = state_r;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_nxt_s     = S_FOLLOW;
            junc_nxt_s      = 4'd0;
            cross_cnt_nxt_s = '0;
            spin_cnt_nxt_s  = '0;
            lost_cnt_nxt_s  = '0;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_FOLLOW: begin
          lost_cnt_nxt_s = '0;
          case (ind_f_r)
            3'b101:         last_cmd_nxt_s = MOT_FWD;
            3'b001, 3'b011: last_cmd_nxt_s = MOT_LEFT;
            3'b100, 3'b110: last_cmd_nxt_s = MOT_RIGHT;
            3'b010:         last_cmd_nxt_s = last_cmd_r;
            3'b000: begin
              state_nxt_s     = S_CROSS;
              cross_cnt_nxt_s = '0;
            end
            default: begin
              lost_cnt_nxt_s = lost_cnt_r + LW'(1);
              state_nxt_s    = (lost_cnt_r == LOST_LAST) ? S_FAULT : S_FOLLOW;
            end
          endcase
        end
        S_CROSS: begin
          cross_cnt_nxt_s = cross_cnt_r + CW'(1);
          if (cross_cnt_r == CROSS_LAST) begin
            case (code_s)
              2'b00: begin
                junc_nxt_s  = junc_r + 4'd1;
                state_nxt_s = (junc_r == LAST_JUNC) ? S_DONE : S_FOLLOW;
              end
              default: begin
                state_nxt_s    = S_TURN;
                spin_cnt_nxt_s = '0;
                spin_dir_nxt_s = (code_s == 2'b01) ? MOT_LEFT : MOT_RIGHT;
                uturn_nxt_s    = (code_s == 2'b11);
              end
            endcase
          end else begin
            state_nxt_s = S_CROSS;
          end
        end
        S_TURN: begin
          if ((spin_cnt_r >= spin_min_s) && !ind_f_r[1]) begin
            junc_nxt_s  = junc_r + 4'd1;
            state_nxt_s = (junc_r == LAST_JUNC) ? S_DONE : S_FOLLOW;
          end else begin
            spin_cnt_nxt_s = spin_cnt_r + TW'(1);
            state_nxt_s    = (spin_cnt_r == TURN_LAST) ? S_FAULT : S_TURN;
          end
        end
        S_BLOCKED: begin
          if (!prox_f_r) begin
            state_nxt_s = ret_r;
          end else begin
            state_nxt_s = S_BLOCKED;
          end
        end
        S_DONE:  state_nxt_s = S_DONE;
        S_FAULT: state_nxt_s = S_FAULT;
        default: state_nxt_s = S_FAULT;
      endcase
    end

    // Motor outputs follow the state being entered; stopped states keep direction.
    case (state_nxt_s)
      S_FOLLOW: begin
        mot_in_nxt_s = last_cmd_nxt_s;
        mot_en_nxt_s = 2'b11;
      end
      S_CROSS: begin
        mot_in_nxt_s = MOT_FWD;
        mot_en_nxt_s = 2'b11;
      end
      S_TURN: begin
        mot_in_nxt_s = spin_dir_nxt_s;
        mot_en_nxt_s = 2'b11;
      end
      default: begin
        mot_in_nxt_s = mot_in_r;
        mot_en_nxt_s = 2'b00;
      end
    endcase
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      ret_r       <= S_IDLE;
      junc_r      <= 4'd0;
      cross_cnt_r <= '0;
      spin_cnt_r  <= '0;
      lost_cnt_r  <= '0;
      last_cmd_r  <= MOT_FWD;
      spin_dir_r  <= MOT_LEFT;
      uturn_r     <= 1'b0;
      mot_in_r    <= MOT_FWD;
      mot_en_r    <= 2'b00;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ret_r       <= ret_nxt_s;
      junc_r      <= junc_nxt_s;
      cross_cnt_r <= cross_cnt_nxt_s;
      spin_cnt_r  <= spin_cnt_nxt_s;
      lost_cnt_r  <= lost_cnt_nxt_s;
      last_cmd_r  <= last_cmd_nxt_s;
      spin_dir_r  <= spin_dir_nxt_s;
      uturn_r     <= uturn_nxt_s;
      mot_in_r    <= mot_in_nxt_s;
      mot_en_r    <= mot_en_nxt_s;
      done_r      <= (state_nxt_s == S_DONE);
      fault_r     <= (state_nxt_s == S_FAULT);
    end
  end

  assign motorIn  = mot_in_r;
  assign motorEn  = mot_en_r;
  assign state    = state_r;
  assign junc_idx = junc_r;
  assign done     = done_r;
  assign fault    = fault_r;

endmodule

// File: tb/tb_line_follow_sequencer.sv
// Directed bench for line_follow_sequencer with small timing parameters
// (DEB=2, CROSS=4, TURN_MIN=3, TURN_MAX=20, LOST=8, two-junction route).
module tb_line_follow_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] induct;
  logic       proxim;
  logic       red;
  logic [3:0] motorIn;
  logic [1:0] motorEn;
  logic [2:0] state;
  logic [3:0] junc_idx;
  logic       done;
  logic       fault;

  int checks = 0;
  int errors = 0;

  line_follow_sequencer #(
    .ROUTE_LEN   (2),
    .ROUTE       (4'b01_00),
    .DEB_CYCLES  (2),
    .CROSS_CYCLES(4),
    .TURN_MIN    (3),
    .TURN_MAX    (20),
    .LOST_CYCLES (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .induct  (induct),
    .proxim  (proxim),
    .red     (red),
    .motorIn (motorIn),
    .motorEn (motorEn),
    .state   (state),
    .junc_idx(junc_idx),
    .done    (done),
    .fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; induct = 3'b111; proxim = 1'b0; red = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Idle -> FOLLOW on 101
  task automatic go_follow();
    induct = 3'b101;
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Run junction 0 (straight) and reach TURN at junction 1 (left)
  task automatic go_turn(input logic [2:0] turn_ind);
    go_follow();
    induct = 3'b000;
    step(3);
    induct = 3'b101;
    step(4);
    induct = 3'b000;
    step(3);
    induct = turn_ind;
    step(4);
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_motorIn", 8'(motorIn), 8'h06);
    chk("rst_motorEn", 8'(motorEn), 8'h0);
    chk("rst_junc", 8'(junc_idx), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_fault", 8'(fault), 8'd0);

    // 1. Basic steering and filter latency
    go_follow();
    chk("s1_follow", 8'(state), 8'd1);
    chk("s1_en", 8'(motorEn), 8'h3);
    chk("s1_fwd", 8'(motorIn), 8'h06);
    induct = 3'b011;
    step(2);
    chk("s1_left_early", 8'(motorIn), 8'h06);
    step(1);
    chk("s1_left", 8'(motorIn), 8'h0A);
    induct = 3'b110;
    step(2);
    chk("s1_right_early", 8'(motorIn), 8'h0A);
    step(1);
    chk("s1_right", 8'(motorIn), 8'h05);
    induct = 3'b010;
    step(3);
    chk("s1_hold", 8'(motorIn), 8'h05);

    // 2. Straight junction then left turn to route completion
    induct = 3'b000;
    step(3);
    chk("s2_cross", 8'(state), 8'd2);
    chk("s2_cross_fwd", 8'(motorIn), 8'h06);
    induct = 3'b101;
    step(3);
    chk("s2_cross_len", 8'(state), 8'd2);
    step(1);
    chk("s2_straight", 8'(state), 8'd1);
    chk("s2_junc1", 8'(junc_idx), 8'd1);
    step(1);
    chk("s2_fwd_again", 8'(motorIn), 8'h06);
    induct = 3'b000;
    step(3);
    chk("s2_cross2", 8'(state), 8'd2);
    induct = 3'b101;
    step(4);
    chk("s2_turn", 8'(state), 8'd3);
    chk("s2_turn_left", 8'(motorIn), 8'h0A);
    step(3);
    chk("s2_turn_min", 8'(state), 8'd3);
    step(1);
    chk("s2_done", 8'(state), 8'd5);
    chk("s2_done_flag", 8'(done), 8'd1);
    chk("s2_done_en", 8'(motorEn), 8'h0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("s2_done_sticky", 8'(state), 8'd5);

    // 3. Obstacle during TURN freezes the spin counter at 2
    do_reset();
    go_turn(3'b111);
    chk("s3_turn", 8'(state), 8'd3);
    proxim = 1'b1;
    step(3);
    chk("s3_blocked", 8'(state), 8'd4);
    chk("s3_blocked_en", 8'(motorEn), 8'h0);
    induct = 3'b101;
    step(2);
    proxim = 1'b0;
    step(2);
    chk("s3_still_blocked", 8'(state), 8'd4);
    step(1);
    chk("s3_resume", 8'(state), 8'd3);
    chk("s3_resume_en", 8'(motorEn), 8'h3);
    chk("s3_resume_dir", 8'(motorIn), 8'h0A);
    step(1);
    chk("s3_count2", 8'(state), 8'd3);
    step(1);
    chk("s3_exit", 8'(state), 8'd5);

    // 4. Turn timeout
    do_reset();
    go_turn(3'b111);
    step(19);
    chk("s4_before_max", 8'(state), 8'd3);
    step(1);
    chk("s4_fault", 8'(state), 8'd6);
    chk("s4_fault_flag", 8'(fault), 8'd1);
    chk("s4_fault_en", 8'(motorEn), 8'h0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("s4_start_ignored", 8'(state), 8'd6);

    // 5. Lost line
    do_reset();
    go_follow();
    induct = 3'b111;
    step(9);
    chk("s5_lost7", 8'(state), 8'd1);
    step(1);
    chk("s5_lost_fault", 8'(state), 8'd6);
    chk("s5_lost_flag", 8'(fault), 8'd1);
    do_reset();
    go_follow();
    induct = 3'b111;
    step(7);
    induct = 3'b101;
    step(3);
    chk("s5_recover", 8'(state), 8'd1);
    induct = 3'b111;
    step(9);
    chk("s5_cleared", 8'(state), 8'd1);
    step(1);
    chk("s5_cleared_fault", 8'(state), 8'd6);

    // 6. Obstacle with junction, then red and reset priority
    do_reset();
    go_follow();
    induct = 3'b000;
    proxim = 1'b1;
    step(3);
    chk("s6_block_wins", 8'(state), 8'd4);
    proxim = 1'b0;
    step(3);
    chk("s6_back_follow", 8'(state), 8'd1);
    step(1);
    chk("s6_redetect", 8'(state), 8'd2);
    red = 1'b1;
    step(1);
    red = 1'b0;
    chk("s6_red_done", 8'(state), 8'd5);
    chk("s6_red_en", 8'(motorEn), 8'h0);
    rst_n = 1'b0;
    step(1);
    chk("s6_rst_state", 8'(state), 8'd0);
    chk("s6_rst_done", 8'(done), 8'd0);
    chk("s6_rst_motorIn", 8'(motorIn), 8'h06);
    rst_n = 1'b1;
    start = 1'b1;
    red = 1'b1;
    step(1);
    start = 1'b0;
    red = 1'b0;
    chk("s6_start_red", 8'(state), 8'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
